// File: rtl/pwm_peripheral_if.sv
// Register-side bundle of the PWM peripheral: enables and duty in, pad outputs and period pulse back.
interface pwm_peripheral_if;
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty;
    logic [15:0] out;
    logic        period_tick;

    modport master (output en_out, en_pwm, duty, input out, period_tick);
    modport slave  (input en_out, en_pwm, duty, output out, period_tick);
endinterface

// File: rtl/pwm_peripheral.sv
// 16-channel phase-aligned PWM / static output driver with a CLK_DIV prescaler.
// Define PWM_SHADOW_EN to latch duty only at period boundaries.
module pwm_lane (
    input  logic clk,
    input  logic rst_n,
    input  logic en_out,
    input  logic en_pwm,
    input  logic pwm_raw,
    output logic out_q
);
    logic out_d;

    always_comb begin
        out_d = en_out & (~en_pwm | pwm_raw);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_q <= 1'b0;
        else        out_q <= out_d;
    end
endmodule

module pwm_peripheral #(
    parameter int unsigned CLK_DIV = 13
) (
    input logic            clk,
    input logic            rst_n,
    pwm_peripheral_if.slave bus
);
    localparam int unsigned NUM_CH   = 16;
    localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0]        div_cnt_q, div_cnt_d;
    logic [7:0]        pwm_cnt_q, pwm_cnt_d;
    logic              period_tick_q, period_tick_d;
    logic [7:0]        duty_act;
    logic              tick, period_end, pwm_raw;
    logic [NUM_CH-1:0] ch_out;

    always_comb begin
        tick          = (div_cnt_q == DIV_LAST);
        period_end    = tick && (pwm_cnt_q == 8'hFF);
        div_cnt_d     = tick ? 8'd0 : div_cnt_q + 8'd1;
        pwm_cnt_d     = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        period_tick_d = period_end;
        // Full scale is forced high so duty=255 never shows the one-count low slot.
        pwm_raw       = (duty_act == 8'hFF) || (pwm_cnt_q < duty_act);
    end

`ifdef PWM_SHADOW_EN
    logic [7:0] duty_act_q, duty_act_d;

    always_comb begin
        duty_act_d = period_end ? bus.duty : duty_act_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) duty_act_q <= 8'd0;
        else        duty_act_q <= duty_act_d;
    end

    assign duty_act = duty_act_q;
`else
    assign duty_act = bus.duty;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q     <= 8'd0;
            pwm_cnt_q     <= 8'd0;
            period_tick_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            pwm_cnt_q     <= pwm_cnt_d;
            period_tick_q <= period_tick_d;
        end
    end

    // One shared compare result fans out to every lane, keeping channels phase-aligned.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        pwm_lane u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_out  (bus.en_out[i]),
            .en_pwm  (bus.en_pwm[i]),
            .pwm_raw (pwm_raw),
            .out_q   (ch_out[i])
        );
    end

    assign bus.out         = ch_out;
    assign bus.period_tick = period_tick_q;
endmodule

// File: tb/tb_pwm_peripheral.sv
// Scoreboard bench: two instances (CLK_DIV=1 and 13) checked every cycle against a cycle-count model.
module tb_pwm_peripheral;
    logic clk = 1'b0;
    logic rst_a_n, rst_b_n;
    always #5 clk = ~clk;

    pwm_peripheral_if bus_a ();
    pwm_peripheral_if bus_b ();

    pwm_peripheral #(.CLK_DIV(1))  dut_a (.clk(clk), .rst_n(rst_a_n), .bus(bus_a));
    pwm_peripheral #(.CLK_DIV(13)) dut_b (.clk(clk), .rst_n(rst_b_n), .bus(bus_b));

    typedef struct {
        logic [15:0] out;
        logic        tick;
    } exp_t;

    exp_t       q_a[$], q_b[$];
    int         checks = 0, errors = 0;
    int         k_a = 0, k_b = 0;
    logic [7:0] sh_a = 8'd0, sh_b = 8'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Expected state after the k-th rising edge since reset release.
    function automatic exp_t model(input int k, input int cd, input logic [7:0] da,
                                   input logic [15:0] eo, input logic [15:0] ep);
        int   cnt;
        logic raw;
        cnt = ((k - 1) / cd) % 256;
        raw = (da == 8'hFF) || (cnt < int'(da));
        model.out  = eo & (~ep | {16{raw}});
        model.tick = (k % (256 * cd)) == 0;
    endfunction

    task automatic step(input bit b);
        exp_t       g;
        logic [7:0] da;
        if (!b) begin
            k_a++;
`ifdef PWM_SHADOW_EN
            da = sh_a;
            if (k_a % 256 == 0) sh_a = bus_a.duty;
`else
            da = bus_a.duty;
`endif
            q_a.push_back(model(k_a, 1, da, bus_a.en_out, bus_a.en_pwm));
        end else begin
            k_b++;
`ifdef PWM_SHADOW_EN
            da = sh_b;
            if (k_b % 3328 == 0) sh_b = bus_b.duty;
`else
            da = bus_b.duty;
`endif
            q_b.push_back(model(k_b, 13, da, bus_b.en_out, bus_b.en_pwm));
        end
        @(posedge clk);
        #1;
        if (!b) begin
            g = q_a.pop_front();
            chk("a_out", bus_a.out, g.out);
            chk("a_tick", bus_a.period_tick, g.tick);
        end else begin
            g = q_b.pop_front();
            chk("b_out", bus_b.out, g.out);
            chk("b_tick", bus_b.period_tick, g.tick);
        end
    endtask

    task automatic drive_a(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        bus_a.en_out = eo;
        bus_a.en_pwm = ep;
        bus_a.duty   = d;
    endtask

    task automatic run_a;
        int hi, nt, first;
        drive_a(16'h0000, 16'h0000, 8'd0);
        rst_a_n = 1'b0;
        #1;
        chk("a_rst_out", bus_a.out, 16'h0);
        chk("a_rst_tick", bus_a.period_tick, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("a_rst_cnt", dut_a.pwm_cnt_q, 8'd0);
        chk("a_rst_out_clk", bus_a.out, 16'h0);
        rst_a_n = 1'b1;
        k_a = 0;
        sh_a = 8'd0;

        // 50% duty on channel 0 only
        drive_a(16'h0001, 16'h0001, 8'd128);
        hi = 0;
        nt = 0;
        for (int i = 1; i <= 600; i++) begin
            step(0);
            if (i > 256 && i <= 512 && bus_a.out[0]) hi++;
            if (bus_a.period_tick) nt++;
        end
        chk("a_high128", hi, 128);
        chk("a_ticks600", nt, 2);

        // Mixed static / PWM / disabled channels
        drive_a(16'hF0F0, 16'h00FF, 8'd64);
        for (int i = 0; i < 512; i++) step(0);

        // Static enable on channel 3: one-cycle latency
        drive_a(16'h0000, 16'h0000, 8'd64);
        step(0);
        chk("a_en3_low", bus_a.out[3], 1'b0);
        drive_a(16'h0008, 16'h0000, 8'd64);
        step(0);
        chk("a_en3_rise", bus_a.out[3], 1'b1);

        // Duty extremes on all channels
        drive_a(16'hFFFF, 16'hFFFF, 8'd0);
        for (int i = 0; i < 300; i++) step(0);
        drive_a(16'hFFFF, 16'hFFFF, 8'd255);
        for (int i = 0; i < 300; i++) step(0);

        // Mid-period duty change at pwm_cnt=100
        drive_a(16'h0001, 16'h0001, 8'd64);
        step(0);
        while (k_a % 256 != 0) step(0);
        repeat (100) step(0);
        chk("a_cnt100", dut_a.pwm_cnt_q, 8'd100);
        bus_a.duty = 8'd200;
        step(0);
`ifdef PWM_SHADOW_EN
        chk("a_duty_chg", bus_a.out[0], 1'b0);
`else
        chk("a_duty_chg", bus_a.out[0], 1'b1);
`endif
        for (int i = 0; i < 400; i++) step(0);

        // Reset mid-period at pwm_cnt=77 with out[0] high
        drive_a(16'h0001, 16'h0001, 8'd128);
        while (k_a % 256 != 77) step(0);
        chk("a_pre_rst_out0", bus_a.out[0], 1'b1);
        #2;
        rst_a_n = 1'b0;
        #1;
        chk("a_arst_out", bus_a.out, 16'h0);
        chk("a_arst_tick", bus_a.period_tick, 1'b0);
        chk("a_arst_pwm", dut_a.pwm_cnt_q, 8'd0);
        chk("a_arst_div", dut_a.div_cnt_q, 8'd0);
        @(posedge clk);
        #1;
        rst_a_n = 1'b1;
        k_a = 0;
        sh_a = 8'd0;
        first = -1;
        for (int i = 1; i <= 300; i++) begin
            step(0);
            if (bus_a.period_tick && first < 0) first = i;
        end
        chk("a_first_tick", first, 256);
    endtask

    task automatic run_b;
        int last;
        bus_b.en_out = 16'hFFFF;
        bus_b.en_pwm = 16'hFFFF;
        bus_b.duty   = 8'd0;
        rst_b_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("b_rst_out", bus_b.out, 16'h0);
        rst_b_n = 1'b1;
        k_b = 0;
        sh_b = 8'd0;
        last = -1;
        for (int i = 0; i < 5 * 3328; i++) begin
            if (i == 2 * 3328) bus_b.duty = 8'd255;
            step(1);
            if (bus_b.period_tick) begin
                if (last >= 0) chk("b_tick_gap", k_b - last, 3328);
                last = k_b;
            end
        end
        chk("b_final_out", bus_b.out, 16'hFFFF);
    endtask

    initial begin
        fork
            run_a();
            run_b();
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pwm_peripheral.md
PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

Interface
REQ-001 Parameter: CLK_DIV, default 13, clk cycles per PWM count step; legal range 1..255.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en_out  input  16  per-channel output enable; [7:0] from SPI register 1, [15:8] from register 2.
REQ-005 en_pwm  input  16  per-channel PWM mode select; [7:0] from register 3, [15:8] from register 4.
REQ-006 duty  input  8  PWM duty cycle, 0..255, from register 5.
REQ-007 out  output  16  registered channel outputs to pads.
REQ-008 period_tick  output  1  registered one-cycle pulse marking the start of each PWM period.

Function
REQ-009 Prescaler div_cnt, 8-bit: counts 0..CLK_DIV-1, then wraps to 0; tick = (div_cnt == CLK_DIV-1); CLK_DIV=1 gives tick every cycle.
REQ-010 Period counter pwm_cnt, 8-bit: increments by 1 on tick only; wraps 255->0 with no stall.
REQ-011 PWM period = 256*CLK_DIV clk cycles; each pwm_cnt value is held for CLK_DIV cycles.
REQ-012 pwm_raw = 1 if duty_act == 255; otherwise pwm_raw = (pwm_cnt < duty_act), unsigned compare.
REQ-013 duty_act == 0 gives pwm_raw constantly 0; duty_act == 255 gives it constantly 1 (no one-count glitch).
REQ-014 Per channel i, next out[i] is:
  - 0 when en_out[i] = 0, regardless of en_pwm[i];
  - 1 when en_out[i] = 1 and en_pwm[i] = 0;
  - pwm_raw when en_out[i] = 1 and en_pwm[i] = 1.
REQ-015 All 16 channels share one pwm_cnt; PWM channels are phase-aligned and switch in the same clk cycle.
REQ-016 Changes to en_out or en_pwm reach out one clk cycle later (registered path, no shadowing).
REQ-017 period_tick registers (tick && pwm_cnt == 255): high for exactly one cycle, the first cycle in which pwm_cnt == 0.
REQ-018 Inputs are quasi-static register values from the SPI block in the clk domain; no input synchronisers.
REQ-019 out has no combinational path from any input.

Reset
REQ-020 While rst_n = 0, these hold at 0 immediately, regardless of clk: out, period_tick, div_cnt, pwm_cnt, duty_act (when shadowed).
REQ-021 Reset mid-period abandons the period; after release the first tick occurs CLK_DIV cycles after the first rising edge.
REQ-022 After release, out reflects the inputs at the first rising edge, with pwm_cnt = 0.

Configuration
REQ-023 Macro PWM_SHADOW_EN:
  - Defined: duty_act is a register loaded from duty only in the cycle with tick && pwm_cnt == 255, so a duty change takes effect at the next period boundary and no period is truncated or stretched.
  - Undefined: duty_act is wired directly to duty; a change affects pwm_raw at the next rising edge, mid-period.
REQ-024 The macro changes no other behaviour, port or reset value.

Verification
REQ-025 CLK_DIV=1, duty=128, en_out=16'h0001, en_pwm=16'h0001:
  - out[0] high 128 cycles, low 128 cycles, period 256;
  - out[15:1] = 0;
  - period_tick every 256 cycles.
REQ-026 CLK_DIV=13, duty=0 then duty=255, en_out=en_pwm=16'hFFFF: out = 16'h0000 constant, then 16'hFFFF constant across full periods; period_tick period 3328 cycles.
REQ-027 CLK_DIV=1, en_out=16'hF0F0, en_pwm=16'h00FF, duty=64:
  - out[15:8] = 8'hF0 static;
  - out[7:4] toggle 64 high / 192 low;
  - out[3:0] = 0.
REQ-028 With PWM_SHADOW_EN, CLK_DIV=1: change duty 64->200 at pwm_cnt=100; current period stays 64 high, next period 200 high. Without the macro: out goes high again at the next edge after the change.
REQ-029 Assert rst_n low at pwm_cnt=77 with out[0]=1: out, period_tick and counters read 0 before the next clk edge; after release pwm_cnt restarts at 0 and the first period_tick arrives 256*CLK_DIV cycles later.
REQ-030 Toggle en_out[3] 0->1 with en_pwm[3]=0: out[3] rises exactly one clk cycle later.
